// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_serial_adder
//  Purpose  : Digit-serial packed-BCD adder/subtractor. Handles one decimal
//             digit per clock, least significant digit first, and uses a
//             start/done handshake. Operand pairs that contain a non-BCD
//             digit are rejected through err without running the datapath.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic                  start,
   input  logic                  mode,
   input  logic                  cin,
   input  logic [4*DIGITS-1:0]   A,
   input  logic [4*DIGITS-1:0]   B,
   output logic [4*DIGITS-1:0]   S,
   output logic                  cout,
   output logic                  err,
   output logic                  busy,
   output logic                  done
);

   localparam int W    = 4 * DIGITS;
   localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    s_q, s_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            mode_q, mode_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            ops_valid;
   logic [3:0]      b_adj;
   logic [4:0]      t_sum;
   logic            t_gt9;
   logic [3:0]      digit;

   // Flag the incoming operand pair as valid only if every nibble is 0..9
   always_comb begin
      ops_valid = 1'b1;
      for (int j = 0; j < DIGITS; j++) begin
         if ((A[4*j +: 4] > 4'd9) || (B[4*j +: 4] > 4'd9)) begin
            ops_valid = 1'b0;
         end
      end
   end

   // One decimal digit slice: subtract uses nine's complement of B plus the
   // initial carry of 1, giving ten's-complement subtraction
   always_comb begin
      b_adj = mode_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
      t_sum = {1'b0, a_q[3:0]} + {1'b0, b_adj} + {4'b0000, carry_q};
      t_gt9 = (t_sum > 5'd9);
      digit = t_gt9 ? (t_sum[3:0] + 4'd6) : t_sum[3:0];
   end

   // Next-state and next-output logic for the IDLE/RUN sequencer
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      idx_d   = idx_q;
      mode_d  = mode_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (busy_q) begin
               // Rejected operands: finish the handshake one cycle later
               busy_d = 1'b0;
               done_d = 1'b1;
            end else if (start) begin
               a_d     = A;
               b_d     = B;
               mode_d  = mode;
               carry_d = mode ? 1'b1 : cin;
               s_d     = '0;
               cout_d  = 1'b0;
               idx_d   = '0;
               busy_d  = 1'b1;
               err_d   = ~ops_valid;
               if (ops_valid) begin
                  state_d = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            for (int j = 0; j < DIGITS; j++) begin
               if (idx_q == IDXW'(j)) begin
                  s_d[4*j +: 4] = digit;
               end
            end
            // Operands shift down so the current digit is always in [3:0]
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            carry_d = t_gt9;
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == LAST_IDX) begin
               cout_d  = t_gt9;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any operation in progress
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         idx_q   <= '0;
         mode_q  <= 1'b0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign S    = s_q;
   assign cout = cout_q;
   assign err  = err_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_serial_adder
//  Purpose  : Directed self-checking bench for bcd_serial_adder (DIGITS=4,
//             plus DIGITS=1 and DIGITS=8 instances).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_serial_adder;

   localparam int D = 4;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic        Resetn, start, mode, cin;
   logic [15:0] A, B, S;
   logic        cout, err, busy, done;

   logic        start1, mode1, cin1;
   logic [3:0]  A1, B1, S1;
   logic        cout1, err1, busy1, done1;

   logic        start8, mode8, cin8;
   logic [31:0] A8, B8, S8;
   logic        cout8, err8, busy8, done8;

   bcd_serial_adder #(.DIGITS(D)) dut (
      .Clock(Clock), .Resetn(Resetn), .start(start), .mode(mode), .cin(cin),
      .A(A), .B(B), .S(S), .cout(cout), .err(err), .busy(busy), .done(done)
   );

   bcd_serial_adder #(.DIGITS(1)) dut1 (
      .Clock(Clock), .Resetn(Resetn), .start(start1), .mode(mode1), .cin(cin1),
      .A(A1), .B(B1), .S(S1), .cout(cout1), .err(err1), .busy(busy1), .done(done1)
   );

   bcd_serial_adder #(.DIGITS(8)) dut8 (
      .Clock(Clock), .Resetn(Resetn), .start(start8), .mode(mode8), .cin(cin8),
      .A(A8), .B(B8), .S(S8), .cout(cout8), .err(err8), .busy(busy8), .done(done8)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] s;
      logic        cout;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic bit bcd_ok(input logic [15:0] v);
      bit ok = 1'b1;
      for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   function automatic int bcd2int(input logic [15:0] v);
      int r = 0;
      for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] int2bcd(input int n);
      logic [15:0] r;
      int m = n;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   // Decimal reference: add/subtract on integers, then wrap to 4 digits
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic md, input logic ci);
      exp_t e;
      int   ia, ib, r;
      if (!bcd_ok(a) || !bcd_ok(b)) begin
         e.s = 16'h0; e.cout = 1'b0; e.err = 1'b1; e.lat = 1;
         return e;
      end
      ia = bcd2int(a);
      ib = bcd2int(b);
      e.err = 1'b0;
      e.lat = D;
      if (!md) begin
         r      = ia + ib + (ci ? 1 : 0);
         e.cout = (r >= 10000);
         e.s    = int2bcd(r % 10000);
      end else begin
         r      = ia - ib;
         e.cout = (ia >= ib);
         e.s    = int2bcd((r + 10000) % 10000);
      end
      return e;
   endfunction

   // Drive one operation, optionally pulse start again poke_at cycles in,
   // then wait for done and compare against the scoreboard head
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic md, input logic ci, input int poke_at);
      exp_t e;
      int   lat, bcnt;
      @(negedge Clock);
      A = a; B = b; mode = md; cin = ci; start = 1'b1;
      sb.push_back(model(a, b, md, ci));
      @(posedge Clock); #1;
      start = 1'b0;
      A = 16'($urandom); B = 16'($urandom); mode = ~md; cin = ~ci;
      lat = 0; bcnt = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         if (lat == poke_at) begin
            start = 1'b1; A = 16'h1111; B = 16'h2222;
         end else begin
            start = 1'b0;
         end
         @(posedge Clock); #1;
         lat++;
      end
      start = 1'b0;
      if (sb.size() == 0) begin
         $display("FAIL scoreboard_empty");
         errors++;
      end else begin
         e = sb.pop_front();
         chk("done_seen",   32'(done), 32'd1);
         chk("latency",     lat, e.lat);
         chk("busy_cycles", bcnt, e.lat);
         chk("S",           32'(S), 32'(e.s));
         chk("cout",        32'(cout), 32'(e.cout));
         chk("err",         32'(err), 32'(e.err));
         chk("busy_at_done", 32'(busy), 32'd0);
         @(posedge Clock); #1;
         chk("done_one_cycle", 32'(done), 32'd0);
         chk("S_hold",      32'(S), 32'(e.s));
      end
   endtask

   initial begin
      int lat, dcnt;
      Resetn = 1'b0; start = 1'b0; mode = 1'b0; cin = 1'b0; A = '0; B = '0;
      start1 = 1'b0; mode1 = 1'b0; cin1 = 1'b0; A1 = '0; B1 = '0;
      start8 = 1'b0; mode8 = 1'b0; cin8 = 1'b0; A8 = '0; B8 = '0;
      #12;
      chk("rst_S",    32'(S), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_err",  32'(err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge Clock);
      Resetn = 1'b1;

      run_op(16'h1234, 16'h5678, 1'b0, 1'b0, -1);
      run_op(16'h9999, 16'h0001, 1'b0, 1'b0, -1);
      run_op(16'h9999, 16'h9999, 1'b0, 1'b1, -1);
      run_op(16'h5000, 16'h1234, 1'b1, 1'b0, -1);
      run_op(16'h0001, 16'h0002, 1'b1, 1'b1, -1);
      run_op(16'h0000, 16'h0000, 1'b1, 1'b0, -1);
      run_op(16'h12A4, 16'h0000, 1'b0, 1'b0, -1);
      run_op(16'h0042, 16'h0013, 1'b0, 1'b0, -1);
      run_op(16'h0458, 16'h0379, 1'b0, 1'b1, 2);

      // Reset in the middle of RUN: outputs clear at once, no done follows
      @(negedge Clock);
      A = 16'h1234; B = 16'h5678; mode = 1'b0; cin = 1'b0; start = 1'b1;
      @(posedge Clock); #1;
      start = 1'b0;
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      chk("partial_S", 32'(S), 32'h0012);
      Resetn = 1'b0;
      #1;
      chk("midrst_S",    32'(S), 32'd0);
      chk("midrst_cout", 32'(cout), 32'd0);
      chk("midrst_err",  32'(err), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      @(negedge Clock);
      @(negedge Clock);
      Resetn = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge Clock); #1;
         if (done) dcnt++;
      end
      chk("no_done_after_rst", dcnt, 0);
      run_op(16'h0005, 16'h0005, 1'b0, 1'b0, -1);

      // DIGITS=1: 9+9+1
      @(negedge Clock);
      A1 = 4'h9; B1 = 4'h9; cin1 = 1'b1; mode1 = 1'b0; start1 = 1'b1;
      @(posedge Clock); #1;
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 40) begin
         @(posedge Clock); #1;
         lat++;
      end
      chk("d1_latency", lat, 1);
      chk("d1_S",       32'(S1), 32'h9);
      chk("d1_cout",    32'(cout1), 32'd1);

      // DIGITS=8: 99999999+1
      @(negedge Clock);
      A8 = 32'h9999_9999; B8 = 32'h0000_0001; cin8 = 1'b0; mode8 = 1'b0; start8 = 1'b1;
      @(posedge Clock); #1;
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 40) begin
         @(posedge Clock); #1;
         lat++;
      end
      chk("d8_latency", lat, 8);
      chk("d8_S",       S8, 32'h0);
      chk("d8_cout",    32'(cout8), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Parametrised, digit-serial BCD adder/subtractor for DIGITS-digit packed-BCD operands. Processes one decimal digit per clock, least significant first, with a start/done handshake. Rejects operands containing non-BCD digits (10–15). Sits between switch/register operand capture and the 7-segment display decoders. Extends the two-digit combinational adder to arbitrary width, adds a subtract mode, and sequences the work over DIGITS cycles.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1)

Ports:
- Clock  in  1  system clock, rising edge
- Resetn  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = add (A+B+cin), 1 = subtract (A−B); sampled with start
- cin  in  1  decimal carry-in for add; ignored in subtract
- A  in  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
- B  in  4*DIGITS  operand B, packed BCD
- S  out  4*DIGITS  result, packed BCD
- cout  out  1  add: decimal carry-out; subtract: 1 = no borrow (A≥B)
- err  out  1  1 = last accepted operand pair contained a non-BCD digit
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse: S/cout/err valid

## Operation
- States: IDLE, RUN.
- IDLE with start=1: latch A, B, mode, and initial carry (cin for add, 1 for subtract). Clear S, cout, and err. Set busy=1 and digit index=0.
  - If any digit of A or B is >9: set err=1, stay in IDLE, pulse done on the next edge, and do not enter RUN.
  - Otherwise go to RUN.
- RUN, each cycle, for digit i:
  - b' = B_i (add) or 9−B_i (subtract, nine's complement).
  - 5-bit sum t = A_i + b' + carry, range 0..19.
  - If t>9: digit = (t+6)[3:0], carry=1. Else digit = t[3:0], carry=0.
  - Write the digit to S[4i+3:4i] and increment i.
- After digit DIGITS−1: cout = final carry, busy=0, done=1 for one cycle, return to IDLE.
- Subtract result:
  - cout=1 → S = A−B.
  - cout=0 → S = 10^DIGITS − (B−A), the ten's complement. Downstream shows the sign.
- S, cout, and err hold their values until the next accepted start.
- start while busy is ignored, with no queuing. Inputs A, B, mode, and cin may change freely after the start edge.

## Timing
- Reset (Resetn=0, asynchronous): state=IDLE, S=0, cout=0, err=0, busy=0, done=0, index=0. Reset mid-operation aborts the operation with no done pulse.
- Let k be the edge that samples start in IDLE.
  - busy rises after edge k.
  - Digit i is written at edge k+1+i.
  - done, cout, and busy=0 take effect at edge k+DIGITS. Latency is DIGITS cycles.
- Error path: err=1 and busy=1 after edge k. done=1 and busy=0 after edge k+1. S=0, cout=0.
- done is high exactly one cycle. A start asserted during the done cycle is accepted at that edge, since the block is in IDLE.
- Intermediate S contents during RUN are partial and not valid until done.
- Throughput: one operation per DIGITS+1 cycles with start held high.

## Test plan
- Add, DIGITS=4: A=1234, B=5678, cin=0 → S=6912, cout=0; done exactly 4 cycles after the start edge; busy high for 4 cycles.
- Carry ripple: A=9999, B=0001, cin=0 → S=0000, cout=1. A=9999, B=9999, cin=1 → S=9999, cout=1.
- Subtract:
  - 5000−1234 → S=3766, cout=1.
  - 0001−0002 → S=9999, cout=0.
  - 0000−0000 → S=0000, cout=1.
- Invalid digit: A=0x12A4, B=0000 → err=1, S=0, cout=0, done 1 cycle after start, no RUN. A following valid start clears err.
- Handshake/reset: start pulsed again 2 cycles into RUN → ignored, result unchanged. Resetn low mid-RUN → all outputs 0 immediately, no done; subsequent 0005+0005 → S=0010.
- DIGITS=1 build: 9+9, cin=1 → S=9, cout=1, done 1 cycle after start. DIGITS=8 build: 99999999+1 → S=0, cout=1 after 8 cycles.
